// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: maps byte/half/word accesses onto a word-only data_mem,
// using a two-cycle read-modify-write for sub-word stores and extending load data for WB.
package codes_pkg;
  localparam int DATA_WIDTH = 32;
endpackage

module load_store_unit #(
  parameter int DATA_WIDTH = codes_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  misalign,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ld_valid,
  output logic [DATA_WIDTH-1:0] ld_data
);

  typedef enum logic {IDLE, RMW} state_t;

  state_t                state, state_next;
  logic                  ld_pend;
  logic [1:0]            ld_lane;
  logic [1:0]            ld_size;
  logic                  ld_unsigned;
  logic [DATA_WIDTH-1:0] rmw_addr;
  logic [1:0]            rmw_lane;
  logic                  rmw_half;
  logic [15:0]           rmw_wdata;
  logic                  illegal;
  logic                  accept;
  logic                  accept_load;
  logic                  accept_sub_store;
  logic [DATA_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] merged;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign word_addr = {2'b00, req_addr[DATA_WIDTH-1:2]};

  always_comb begin
    illegal = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end

  // Requests are only looked at in IDLE; in RMW upstream is still holding the store.
  assign accept           = (state == IDLE) && req_valid && !illegal;
  assign accept_load      = accept && !req_we;
  assign accept_sub_store = accept && req_we && (req_size != 2'b10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_sub_store) state_next = RMW;
      RMW:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    misalign  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        misalign = req_valid && illegal;
        if (accept) begin
          mem_addr = word_addr;
          if (!req_we) begin
            mem_read = 1'b1;
          end else if (req_size == 2'b10) begin
            mem_write = 1'b1;
            mem_wdata = req_wdata;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
          end
        end
      end
      RMW: begin
        mem_write = 1'b1;
        mem_addr  = rmw_addr;
        mem_wdata = merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_pend     <= 1'b0;
      ld_lane     <= 2'b00;
      ld_size     <= 2'b00;
      ld_unsigned <= 1'b0;
      rmw_addr    <= '0;
      rmw_lane    <= 2'b00;
      rmw_half    <= 1'b0;
      rmw_wdata   <= '0;
    end else begin
      ld_pend <= accept_load;
      if (accept_load) begin
        ld_lane     <= req_addr[1:0];
        ld_size     <= req_size;
        ld_unsigned <= req_unsigned;
      end
      if (accept_sub_store) begin
        rmw_addr  <= word_addr;
        rmw_lane  <= req_addr[1:0];
        rmw_half  <= (req_size == 2'b01);
        rmw_wdata <= req_wdata[15:0];
      end
    end
  end

  // Little-endian lane replacement over the word read back during the RMW cycle.
  always_comb begin
    merged = mem_rdata;
    if (rmw_half) merged[{rmw_lane[1], 4'b0000} +: 16] = rmw_wdata;
    else          merged[{rmw_lane, 3'b000} +: 8]      = rmw_wdata[7:0];
  end

  always_comb begin
    ld_byte  = mem_rdata[{ld_lane, 3'b000} +: 8];
    ld_half  = mem_rdata[{ld_lane[1], 4'b0000} +: 16];
    ld_valid = ld_pend;
    ld_data  = '0;
    if (ld_pend) begin
      case (ld_size)
        2'b00:   ld_data = {{(DATA_WIDTH-8){ld_byte[7] & ~ld_unsigned}}, ld_byte};
        2'b01:   ld_data = {{(DATA_WIDTH-16){ld_half[15] & ~ld_unsigned}}, ld_half};
        default: ld_data = mem_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a byte-addressed memory model predicts every
// data_mem access and every write-back result.
module tb_load_store_unit;

  localparam int DW    = 32;
  localparam int WORDS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          stall;
  logic          misalign;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          ld_valid;
  logic [DW-1:0] ld_data;

  logic [DW-1:0] dmem [WORDS];
  logic [7:0]    ref_mem [4*WORDS];

  int            checks = 0;
  int            errors = 0;
  bit            exp_ld_valid = 1'b0;
  logic [DW-1:0] exp_ld_data = '0;

  load_store_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .misalign(misalign),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  // Word-addressed data_mem stand-in with registered read data.
  always @(posedge clk) begin
    if (mem_read)  mem_rdata <= dmem[mem_addr[3:0]];
    if (mem_write) dmem[mem_addr[3:0]] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_word(input int a);
    int b;
    b = a & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [DW-1:0] ref_load(input int a, input int sz, input bit uns);
    int v;
    if (sz == 0) begin
      v = ref_mem[a];
      if (!uns && v > 127) v -= 256;
      return DW'(v);
    end else if (sz == 1) begin
      v = ref_mem[a] + 256 * ref_mem[a+1];
      if (!uns && v > 32767) v -= 65536;
      return DW'(v);
    end
    return ref_word(a);
  endfunction

  function automatic bit is_legal(input int a, input int sz);
    if (sz == 3) return 1'b0;
    if (sz == 1 && (a % 2) != 0) return 1'b0;
    if (sz == 2 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_prev_load();
    checkOutput("ld_valid", DW'(ld_valid), DW'(exp_ld_valid));
    if (exp_ld_valid) checkOutput("ld_data", ld_data, exp_ld_data);
  endtask

  task automatic idleCycle();
    req_valid = 1'b0;
    @(negedge clk);
    check_prev_load();
    checkOutput("idle_bus", {stall, misalign, mem_read, mem_write}, '0);
    checkOutput("idle_addr", mem_addr, '0);
    checkOutput("idle_wdata", mem_wdata, '0);
    exp_ld_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives one request starting just after a rising edge; covers the RMW cycle when needed.
  task automatic applyStimulus(input bit we, input int sz, input bit uns,
                               input int a, input logic [DW-1:0] wd);
    bit ok;
    ok = is_legal(a, sz);
    req_valid = 1'b1; req_we = we; req_size = 2'(sz); req_unsigned = uns;
    req_addr = DW'(a); req_wdata = wd;
    @(negedge clk);
    check_prev_load();
    checkOutput("misalign", DW'(misalign), DW'(!ok));
    if (!ok) begin
      checkOutput("bad_bus", {stall, mem_read, mem_write}, '0);
      checkOutput("bad_addr", mem_addr, '0);
    end else if (!we) begin
      checkOutput("ld_bus", {stall, mem_read, mem_write}, DW'(3'b010));
      checkOutput("ld_addr", mem_addr, DW'(a / 4));
    end else if (sz == 2) begin
      checkOutput("sw_bus", {stall, mem_read, mem_write}, DW'(3'b001));
      checkOutput("sw_addr", mem_addr, DW'(a / 4));
      checkOutput("sw_wdata", mem_wdata, wd);
    end else begin
      checkOutput("rmw_rd_bus", {stall, mem_read, mem_write}, DW'(3'b110));
      checkOutput("rmw_rd_addr", mem_addr, DW'(a / 4));
    end
    exp_ld_valid = ok && !we;
    if (exp_ld_valid) exp_ld_data = ref_load(a, sz, uns);
    @(posedge clk); #1;
    if (ok && we) begin
      ref_mem[a] = wd[7:0];
      if (sz >= 1) ref_mem[a+1] = wd[15:8];
      if (sz == 2) begin
        ref_mem[a+2] = wd[23:16];
        ref_mem[a+3] = wd[31:24];
      end else begin
        @(negedge clk);
        checkOutput("rmw_ld_valid", DW'(ld_valid), '0);
        checkOutput("rmw_wr_bus", {stall, misalign, mem_read, mem_write}, DW'(4'b0001));
        checkOutput("rmw_wr_addr", mem_addr, DW'(a / 4));
        checkOutput("rmw_wr_data", mem_wdata, ref_word(a));
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [DW-1:0] r;
    int            a, sz;
    bit            we;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int w = 0; w < WORDS; w++) begin
      r = $urandom;
      dmem[w] = r;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = r[8*b +: 8];
    end

    @(negedge clk);
    checkOutput("rst_bus", {stall, misalign, mem_read, mem_write, ld_valid}, '0);
    checkOutput("rst_addr", mem_addr, '0);
    checkOutput("rst_wdata", mem_wdata, '0);
    checkOutput("rst_ld_data", ld_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] directed sequences");
    applyStimulus(1, 2, 0, 'h10, 32'hDEADBEEF);
    applyStimulus(0, 2, 0, 'h10, '0);
    applyStimulus(1, 0, 0, 'h13, 32'h000000AA);
    checkOutput("sb_word", ref_word('h10), 32'hAAADBEEF);
    applyStimulus(0, 0, 0, 'h13, '0);
    checkOutput("lb_value", exp_ld_data, 32'hFFFFFFAA);
    applyStimulus(0, 0, 1, 'h13, '0);
    applyStimulus(1, 2, 0, 'h10, 32'hDEADBEEF);
    applyStimulus(1, 1, 0, 'h12, 32'h00001234);
    applyStimulus(0, 1, 0, 'h10, '0);
    applyStimulus(0, 1, 1, 'h10, '0);
    applyStimulus(0, 1, 0, 'h12, '0);
    checkOutput("lh_hi_value", exp_ld_data, 32'h00001234);
    idleCycle();
    applyStimulus(0, 2, 0, 'h11, '0);
    applyStimulus(1, 1, 0, 'h13, 32'h0000BEEF);
    applyStimulus(0, 3, 0, 'h10, '0);
    idleCycle();
    applyStimulus(0, 2, 0, 'h10, '0);
    applyStimulus(1, 0, 0, 'h10, 32'h00000055);
    applyStimulus(0, 0, 1, 'h10, '0);
    checkOutput("lbu_merged", exp_ld_data, 32'h00000055);
    idleCycle();

    $display("[TB] reset during RMW");
    r = ref_word('h10);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 'h11; req_wdata = 32'h000000C3;
    @(negedge clk);
    checkOutput("abort_stall", DW'(stall), 1);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    checkOutput("abort_bus", {stall, mem_read, mem_write, ld_valid}, '0);
    checkOutput("abort_ld_data", ld_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ld_valid = 1'b0;
    applyStimulus(0, 2, 0, 'h10, '0);
    checkOutput("abort_word", exp_ld_data, r);
    idleCycle();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idleCycle();
      end else begin
        we = 1'($urandom_range(0, 1));
        sz = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
        a  = $urandom_range(0, 4*WORDS-1);
        if ($urandom_range(0, 4) != 0) begin
          if (sz == 1) a &= ~1;
          if (sz == 2) a &= ~3;
        end
        applyStimulus(we, sz, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
